// File: rtl/spi_responder.sv
// spi_responder: SPI mode-0 slave with TX/RX byte FIFOs and sticky error flags.
// Optional input synchronizers are enabled by defining SPI_RESP_SYNC_EN; without it,
// the SPI inputs are used directly and the master must run from the same clk.
module spi_responder #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       IN_SPI_clk,
  input  logic       IN_SPI_mosi,
  input  logic       IN_SPI_cs_n,
  output logic       OUT_SPI_miso,
  input  logic       IN_txValid,
  input  logic [7:0] IN_txData,
  output logic       OUT_txReady,
  output logic       OUT_rxValid,
  output logic [7:0] OUT_rxData,
  input  logic       IN_rxReady,
  input  logic       IN_clrFlags,
  output logic       OUT_rxOverflow,
  output logic       OUT_txUnderflow,
  output logic       OUT_busy
);

  localparam int TW = $clog2(TX_DEPTH);
  localparam int RW = $clog2(RX_DEPTH);

  logic spi_clk, spi_mosi, spi_cs_n;

`ifdef SPI_RESP_SYNC_EN
  logic [1:0] clk_sync_q, mosi_sync_q, cs_sync_q;

  // Two-flop synchronizers for an asynchronous master; idle values on reset
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q  <= 2'b00;
      mosi_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], IN_SPI_clk};
      mosi_sync_q <= {mosi_sync_q[0], IN_SPI_mosi};
      cs_sync_q   <= {cs_sync_q[0], IN_SPI_cs_n};
    end
  end

  assign spi_clk  = clk_sync_q[1];
  assign spi_mosi = mosi_sync_q[1];
  assign spi_cs_n = cs_sync_q[1];
`else
  assign spi_clk  = IN_SPI_clk;
  assign spi_mosi = IN_SPI_mosi;
  assign spi_cs_n = IN_SPI_cs_n;
`endif

  // Bit engine state
  logic       clkPrev_q;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] rxShift_q, rxShift_d;
  logic [7:0] txShift_q, txShift_d;
  logic       miso_q, miso_d;
  logic       ovf_q, ovf_d, und_q, und_d;

  // FIFO storage and pointers (index plus wrap bit)
  logic [7:0] tx_mem_q [TX_DEPTH];
  logic [7:0] rx_mem_q [RX_DEPTH];
  logic [TW:0] tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
  logic [RW:0] rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;

  logic       rise;
  logic       tx_empty, tx_full, rx_empty, rx_full;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       rx_drop, tx_under;
  logic [7:0] tx_head;

  assign tx_empty = (tx_wr_q == tx_rd_q);
  assign tx_full  = (tx_wr_q[TW-1:0] == tx_rd_q[TW-1:0]) && (tx_wr_q[TW] != tx_rd_q[TW]);
  assign rx_empty = (rx_wr_q == rx_rd_q);
  assign rx_full  = (rx_wr_q[RW-1:0] == rx_rd_q[RW-1:0]) && (rx_wr_q[RW] != rx_rd_q[RW]);
  assign tx_head  = tx_mem_q[tx_rd_q[TW-1:0]];

  // Rising SPI clock edges only count while selected
  assign rise    = spi_clk & ~clkPrev_q & ~spi_cs_n;
  assign tx_push = IN_txValid & ~tx_full;
  assign rx_pop  = IN_rxReady & ~rx_empty;

  // Bit engine next state: shift on each detected edge, FIFO handoff at byte boundaries
  always_comb begin
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    tx_pop    = 1'b0;
    rx_push   = 1'b0;
    rx_drop   = 1'b0;
    tx_under  = 1'b0;
    if (spi_cs_n) begin
      // Deselect abandons any partial byte
      bitCnt_d  = 3'd0;
      rxShift_d = 8'h00;
    end else if (rise) begin
      rxShift_d = {rxShift_q[6:0], spi_mosi};
      bitCnt_d  = bitCnt_q + 3'd1;
      if (bitCnt_q == 3'd0) begin
        // Head bit 7 is already on miso, so load the rest of the byte
        if (tx_empty) begin
          txShift_d = 8'hFF;
          tx_under  = 1'b1;
        end else begin
          txShift_d = {tx_head[6:0], 1'b1};
          tx_pop    = 1'b1;
        end
      end else begin
        txShift_d = {txShift_q[6:0], 1'b1};
      end
      if (bitCnt_q == 3'd7) begin
        if (rx_full) rx_drop = 1'b1;
        else         rx_push = 1'b1;
      end
    end
  end

  // miso: idle/byte-boundary shows the next TX head bit, otherwise tracks the shifter
  always_comb begin
    miso_d = miso_q;
    if (spi_cs_n || (bitCnt_q == 3'd0 && !rise))
      miso_d = tx_empty ? 1'b1 : tx_head[7];
    else if (rise)
      miso_d = txShift_d[7];
  end

  // Pointer and flag next state; a same-cycle set beats the clear
  always_comb begin
    tx_wr_d = tx_wr_q + {{TW{1'b0}}, tx_push};
    tx_rd_d = tx_rd_q + {{TW{1'b0}}, tx_pop};
    rx_wr_d = rx_wr_q + {{RW{1'b0}}, rx_push};
    rx_rd_d = rx_rd_q + {{RW{1'b0}}, rx_pop};
    ovf_d   = rx_drop  | (ovf_q & ~IN_clrFlags);
    und_d   = tx_under | (und_q & ~IN_clrFlags);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clkPrev_q <= 1'b0;
      bitCnt_q  <= 3'd0;
      rxShift_q <= 8'h00;
      txShift_q <= 8'hFF;
      miso_q    <= 1'b1;
      ovf_q     <= 1'b0;
      und_q     <= 1'b0;
      tx_wr_q   <= '0;
      tx_rd_q   <= '0;
      rx_wr_q   <= '0;
      rx_rd_q   <= '0;
    end else begin
      clkPrev_q <= spi_clk;
      bitCnt_q  <= bitCnt_d;
      rxShift_q <= rxShift_d;
      txShift_q <= txShift_d;
      miso_q    <= miso_d;
      ovf_q     <= ovf_d;
      und_q     <= und_d;
      tx_wr_q   <= tx_wr_d;
      tx_rd_q   <= tx_rd_d;
      rx_wr_q   <= rx_wr_d;
      rx_rd_q   <= rx_rd_d;
    end
  end

  // FIFO data arrays need no reset; pointers define validity
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem_q[tx_wr_q[TW-1:0]] <= IN_txData;
    if (rx_push) rx_mem_q[rx_wr_q[RW-1:0]] <= rxShift_d;
  end

  assign OUT_SPI_miso    = miso_q;
  assign OUT_txReady     = ~tx_full;
  assign OUT_rxValid     = ~rx_empty;
  assign OUT_rxData      = rx_mem_q[rx_rd_q[RW-1:0]];
  assign OUT_rxOverflow  = ovf_q;
  assign OUT_txUnderflow = und_q;
  assign OUT_busy        = ~spi_cs_n | (bitCnt_q != 3'd0);

endmodule

// File: tb/tb_spi_responder.sv
// tb_spi_responder: directed scenarios plus randomized frames against a queue-based model.
module tb_spi_responder;
  localparam int TXD = 4;
  localparam int RXD = 4;
`ifdef SPI_RESP_SYNC_EN
  localparam int PH = 4;
`else
  localparam int PH = 1;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       IN_SPI_clk = 1'b0, IN_SPI_mosi = 1'b0, IN_SPI_cs_n = 1'b1;
  logic       OUT_SPI_miso;
  logic       IN_txValid = 1'b0;
  logic [7:0] IN_txData = 8'h00;
  logic       OUT_txReady, OUT_rxValid;
  logic [7:0] OUT_rxData;
  logic       IN_rxReady = 1'b0, IN_clrFlags = 1'b0;
  logic       OUT_rxOverflow, OUT_txUnderflow, OUT_busy;

  always #5 clk = ~clk;

  spi_responder #(.TX_DEPTH(TXD), .RX_DEPTH(RXD)) dut (
    .clk(clk), .rst(rst),
    .IN_SPI_clk(IN_SPI_clk), .IN_SPI_mosi(IN_SPI_mosi), .IN_SPI_cs_n(IN_SPI_cs_n),
    .OUT_SPI_miso(OUT_SPI_miso),
    .IN_txValid(IN_txValid), .IN_txData(IN_txData), .OUT_txReady(OUT_txReady),
    .OUT_rxValid(OUT_rxValid), .OUT_rxData(OUT_rxData), .IN_rxReady(IN_rxReady),
    .IN_clrFlags(IN_clrFlags), .OUT_rxOverflow(OUT_rxOverflow),
    .OUT_txUnderflow(OUT_txUnderflow), .OUT_busy(OUT_busy)
  );

  // Reference model: byte queues and sticky flags
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  logic       m_ovf = 1'b0, m_und = 1'b0;
  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".rxValid"}, OUT_rxValid, rx_q.size() != 0);
    if (rx_q.size() != 0) chk({tag, ".rxData"}, OUT_rxData, rx_q[0]);
    chk({tag, ".txReady"}, OUT_txReady, tx_q.size() < TXD);
    chk({tag, ".ovf"}, OUT_rxOverflow, m_ovf);
    chk({tag, ".und"}, OUT_txUnderflow, m_und);
    chk({tag, ".busy"}, OUT_busy, 1'b0);
    chk({tag, ".miso_idle"}, OUT_SPI_miso, (tx_q.size() != 0) ? tx_q[0][7] : 1'b1);
  endtask

  task automatic tx_push(input logic [7:0] b);
    chk("txReady_pre", OUT_txReady, tx_q.size() < TXD);
    IN_txValid = 1'b1; IN_txData = b;
    tick();
    IN_txValid = 1'b0;
    if (tx_q.size() < TXD) tx_q.push_back(b);
  endtask

  task automatic rx_pop();
    chk("pop.rxValid", OUT_rxValid, rx_q.size() != 0);
    if (rx_q.size() != 0) chk("pop.rxData", OUT_rxData, rx_q[0]);
    IN_rxReady = 1'b1;
    tick();
    IN_rxReady = 1'b0;
    if (rx_q.size() != 0) void'(rx_q.pop_front());
  endtask

  task automatic clr_flags();
    IN_clrFlags = 1'b1;
    tick();
    IN_clrFlags = 1'b0;
    m_ovf = 1'b0; m_und = 1'b0;
  endtask

  // One master bit: present mosi, hold low, sample miso, pulse clk high
  task automatic xfer_bit(input logic mo, output logic mi);
    IN_SPI_mosi = mo;
    tick(PH);
    mi = OUT_SPI_miso;
    IN_SPI_clk = 1'b1;
    tick(PH);
    IN_SPI_clk = 1'b0;
  endtask

  // Frame of nb (1..4) complete bytes, MSB-first bytes taken from data
  task automatic frame(input int nb, input logic [31:0] data);
    logic [7:0] mo, mi, exp_mi;
    logic       bit_in;
    IN_SPI_cs_n = 1'b0;
    for (int b = 0; b < nb; b++) begin
      mo = data[8*(nb-1-b) +: 8];
      if (tx_q.size() != 0) exp_mi = tx_q.pop_front();
      else begin exp_mi = 8'hFF; m_und = 1'b1; end
      for (int i = 7; i >= 0; i--) begin
        xfer_bit(mo[i], bit_in);
        mi[i] = bit_in;
        if (b == 0 && i == 7) chk("busy_in_frame", OUT_busy, 1'b1);
      end
      chk("miso_byte", mi, exp_mi);
      if (rx_q.size() == RXD) m_ovf = 1'b1;
      else rx_q.push_back(mo);
    end
    tick(PH);
    IN_SPI_cs_n = 1'b1;
    tick(PH + 4);
  endtask

  // Frame aborted by cs_n after k (1..7) bits: head byte consumed, nothing received
  task automatic partial(input int k, input logic [7:0] mo);
    logic bit_in;
    IN_SPI_cs_n = 1'b0;
    if (tx_q.size() != 0) void'(tx_q.pop_front());
    else m_und = 1'b1;
    for (int i = 7; i > 7 - k; i--) xfer_bit(mo[i], bit_in);
    tick(PH);
    IN_SPI_cs_n = 1'b1;
    tick(PH + 4);
  endtask

  initial begin
    logic bit_in;
    // 1. reset state
    tick(3);
    check_state("reset_held");
    rst = 1'b0;
    tick(2);
    check_state("reset");

    // 2. single byte exchange
    tx_push(8'hA5);
    tick();
    frame(1, 32'h3C);
    check_state("byte");
    chk("byte.rxData", OUT_rxData, 8'h3C);
    rx_pop();
    check_state("byte_popped");

    // 3. underflow, 16-bit frame
    frame(2, 32'h1234);
    check_state("under");
    chk("under.flag", OUT_txUnderflow, 1'b1);
    rx_pop(); rx_pop();
    clr_flags();
    check_state("under_clr");

    // 4. RX overflow
    frame(4, 32'h01020304);
    frame(1, 32'h05);
    check_state("ovf");
    chk("ovf.flag", OUT_rxOverflow, 1'b1);
    for (int i = 0; i < 4; i++) rx_pop();
    clr_flags();
    check_state("ovf_clr");

    // 5. aborted byte then a clean one
    partial(5, 8'hFF);
    frame(1, 32'h81);
    check_state("abort");
    chk("abort.rxData", OUT_rxData, 8'h81);
    rx_pop();
    clr_flags();

    // 6. reset mid-frame with both FIFOs holding data
    tx_push(8'h11); tx_push(8'h22);
    tick();
    frame(1, 32'h77);
    IN_SPI_cs_n = 1'b0;
    for (int i = 0; i < 3; i++) xfer_bit(1'b1, bit_in);
    rst = 1'b1; IN_SPI_cs_n = 1'b1; IN_SPI_clk = 1'b0;
    tx_q.delete(); rx_q.delete(); m_ovf = 1'b0; m_und = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(2);
    check_state("rst_mid");
    tx_push(8'h5A);
    tick();
    frame(1, 32'hC3);
    check_state("after_rst");

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      int np, nb, nr;
      np = $urandom_range(0, 3);
      for (int j = 0; j < np; j++) tx_push(8'($urandom));
      tick();
      if ($urandom_range(0, 7) == 0) partial($urandom_range(1, 7), 8'($urandom));
      nb = $urandom_range(1, 3);
      frame(nb, $urandom);
      check_state("rnd_frame");
      nr = $urandom_range(0, 3);
      for (int j = 0; j < nr; j++) rx_pop();
      if ($urandom_range(0, 3) == 0) clr_flags();
      tick();
      check_state("rnd_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
